// File: rtl/rr_arbiter_32.sv
// Round-robin arbiter, 32 requesters, grant held until release.
// Ports: clk, rst_n, req, mask, rel -> gnt, gnt_idx, gnt_vld, ptr, tmo.
// Optional forced release: define ARB_TIMEOUT_EN (uses TIMEOUT_CYC).
module rr_arbiter_32 #(
  parameter int N_REQ       = 32,
  parameter int IDX_W       = 6,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic [$clog2(N_REQ)-1:0] ptr,
  output logic             tmo
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [IDX_W-1:0] NONE = IDX_W'(N_REQ);

  if (N_REQ != 32 || IDX_W != 6 ||
      TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad
    $error("rr_arbiter_32: unsupported parameters");
  end

  typedef enum logic {
    S_IDLE,
    S_HOLD
  } state_t;

  state_t           r_state;
  logic [N_REQ-1:0] r_gnt;
  logic [IDX_W-1:0] r_idx;
  logic             r_vld;
  logic [PW-1:0]    r_ptr;

  logic [N_REQ-1:0]   w_elig;
  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;
  logic [PW-1:0]      w_off;
  logic [PW-1:0]      w_win;

  assign w_elig = req & mask;
  // Rotate so the pointer position lands at bit 0, then pick the
  // lowest set bit; adding ptr back wraps modulo 32 for free.
  assign w_dbl  = {w_elig, w_elig};
  assign w_rot  = w_dbl[r_ptr +: N_REQ];

  always_comb begin
    w_off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = PW'(i);
    end
  end

  assign w_win = w_off + r_ptr;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIM = 8'(TIMEOUT_CYC - 1);
  logic [7:0] r_cnt;
  logic       r_tmo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_gnt   <= '0;
      r_idx   <= NONE;
      r_vld   <= 1'b0;
      r_ptr   <= '0;
`ifdef ARB_TIMEOUT_EN
      r_cnt   <= '0;
      r_tmo   <= 1'b0;
`endif
    end else begin
`ifdef ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          if (|w_elig) begin
            r_gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
            r_idx   <= IDX_W'(w_win);
            r_vld   <= 1'b1;
            r_state <= S_HOLD;
`ifdef ARB_TIMEOUT_EN
            r_cnt   <= '0;
`endif
          end
        end
        S_HOLD: begin
          if (rel) begin
            r_gnt   <= '0;
            r_idx   <= NONE;
            r_vld   <= 1'b0;
            r_ptr   <= r_idx[PW-1:0] + 1'b1;
            r_state <= S_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (r_cnt == LIM) begin
            r_gnt   <= '0;
            r_idx   <= NONE;
            r_vld   <= 1'b0;
            r_ptr   <= r_idx[PW-1:0] + 1'b1;
            r_state <= S_IDLE;
            r_tmo   <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
`endif
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt     = r_gnt;
  assign gnt_idx = r_idx;
  assign gnt_vld = r_vld;
  assign ptr     = r_ptr;
`ifdef ARB_TIMEOUT_EN
  assign tmo     = r_tmo;
`else
  assign tmo     = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_32.sv
// Directed bench for rr_arbiter_32 with an expected-result queue.
// Each step queues the expected post-edge state, then checks it.
module tb_rr_arbiter_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] req = '0;
  logic [31:0] mask = '0;
  logic        rel = 1'b0;
  logic [31:0] gnt;
  logic [5:0]  gnt_idx;
  logic        gnt_vld;
  logic [4:0]  ptr;
  logic        tmo;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int    idx;
    int    ptr;
    bit    tmo;
    string tag;
  } exp_t;

  exp_t q[$];

  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  rr_arbiter_32 #(.TIMEOUT_CYC(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .mask    (mask),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .ptr     (ptr),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s.%s got %h exp %h", tag, fld, got, exp);
    end
  endtask

  task automatic check_front();
    exp_t        e;
    logic [31:0] eg;
    if (q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty got 0 exp 1");
      return;
    end
    e  = q.pop_front();
    eg = (e.idx == 32) ? 32'h0 : (32'h1 << e.idx);
    chk(e.tag, "gnt_idx", 32'(gnt_idx), 32'(e.idx));
    chk(e.tag, "gnt", gnt, eg);
    chk(e.tag, "gnt_vld", 32'(gnt_vld), 32'(e.idx != 32));
    chk(e.tag, "ptr", 32'(ptr), 32'(e.ptr));
    chk(e.tag, "tmo", 32'(tmo), 32'(e.tmo));
  endtask

  task automatic step(input logic [31:0] r, input logic [31:0] m,
                      input logic rl, input int eidx, input int eptr,
                      input bit etmo, input string tag);
    req  = r;
    mask = m;
    rel  = rl;
    q.push_back('{eidx, eptr, etmo, tag});
    @(posedge clk);
    #1;
    check_front();
  endtask

  task automatic do_reset();
    req   = '0;
    mask  = ALL;
    rel   = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.push_back('{32, 0, 1'b0, "reset"});
    check_front();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    step(32'h1, ALL, 1'b0, 0, 0, 1'b0, "g0");
    step(32'h1, ALL, 1'b1, 32, 1, 1'b0, "rel0");
    step(32'h0, ALL, 1'b0, 32, 1, 1'b0, "idle0");

    do_reset();
    for (int k = 0; k <= 32; k++) begin
      step(ALL, ALL, 1'b0, k % 32, k % 32, 1'b0, "rr_gnt");
      step(ALL, ALL, 1'b0, k % 32, k % 32, 1'b0, "rr_hold");
      step(ALL, ALL, 1'b1, 32, (k + 1) % 32, 1'b0, "rr_rel");
    end

    do_reset();
    step(32'h2000_0000, ALL, 1'b0, 29, 0, 1'b0, "g29");
    step(32'h0, ALL, 1'b1, 32, 30, 1'b0, "p30");
    step(32'h8000_0004, ALL, 1'b0, 31, 30, 1'b0, "wrap31");
    step(32'h8000_0004, ALL, 1'b1, 32, 0, 1'b0, "rel31");
    step(32'h8000_0004, ALL, 1'b0, 2, 0, 1'b0, "wrap2");
    step(32'h8000_0004, ALL, 1'b1, 32, 3, 1'b0, "p3");

    step(32'h20, ~32'h20, 1'b0, 32, 3, 1'b0, "mask5a");
    step(32'h20, ~32'h20, 1'b0, 32, 3, 1'b0, "mask5b");
    step(32'h20, ALL, 1'b0, 5, 3, 1'b0, "unmask5");
    step(32'h20, ALL, 1'b1, 32, 6, 1'b0, "rel5");

    step(32'h0, ALL, 1'b1, 32, 6, 1'b0, "rel_idle");
    step(32'h80, ALL, 1'b0, 7, 6, 1'b0, "g7");
    step(32'h0, ALL, 1'b0, 7, 6, 1'b0, "h7_noreq");
    step(32'h0, 32'h0, 1'b0, 7, 6, 1'b0, "h7_mask0");
    step(ALL, 32'h0, 1'b0, 7, 6, 1'b0, "h7_other");
    step(ALL, ALL, 1'b0, 7, 6, 1'b0, "h7_all");

    rst_n = 1'b0;
    #1;
    q.push_back('{32, 0, 1'b0, "async_rst"});
    check_front();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef ARB_TIMEOUT_EN
    step(32'h200, ALL, 1'b0, 9, 0, 1'b0, "t_g9");
    step(32'h0, ALL, 1'b0, 9, 0, 1'b0, "t_h1");
    step(32'h0, ALL, 1'b0, 9, 0, 1'b0, "t_h2");
    step(32'h0, ALL, 1'b0, 9, 0, 1'b0, "t_h3");
    step(32'h0, ALL, 1'b0, 32, 10, 1'b1, "t_force");
    step(32'h0, ALL, 1'b0, 32, 10, 1'b0, "t_pulse");
    step(32'h200, ALL, 1'b0, 9, 10, 1'b0, "t_g9b");
    step(32'h0, ALL, 1'b0, 9, 10, 1'b0, "t_h1b");
    step(32'h0, ALL, 1'b0, 9, 10, 1'b0, "t_h2b");
    step(32'h0, ALL, 1'b0, 9, 10, 1'b0, "t_h3b");
    step(32'h0, ALL, 1'b1, 32, 10, 1'b0, "t_relwin");
`else
    step(32'h200, ALL, 1'b0, 9, 0, 1'b0, "p_g9");
    for (int c = 0; c < 1000; c++) begin
      step(32'h0, ALL, 1'b0, 9, 0, 1'b0, "p_hold9");
    end
    step(32'h0, ALL, 1'b1, 32, 10, 1'b0, "p_rel9");
`endif

    checks++;
    assert (q.size() == 0) else begin
      errors++;
      $error("FAIL sb_left got %0d exp 0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
